// File: rtl/bit8_pkg.sv
// ----------------------------------------------------------------------------
// bit8_pkg
// Shared definitions for the bit8 serial-transfer blocks.
//   tx_state_t        : transmitter FSM states (PARITY is only reachable
//                       when the design is built with PARITY_EN defined)
//   BIT8_W            : default data word width
//   BIT8_DIV_DEFAULT  : default clocks per serial bit period
// ----------------------------------------------------------------------------
package bit8_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } tx_state_t;

    localparam int BIT8_W           = 8;
    localparam int BIT8_DIV_DEFAULT = 4;

endpackage

// File: rtl/bit8_bit_divider.sv
// ----------------------------------------------------------------------------
// bit8_bit_divider
// Enable-gated modulo-DIV counter that marks the last cycle of each serial
// bit period.
// Ports:
//   clock     in  rising-edge clock
//   reset     in  asynchronous, active-high reset (clears the count)
//   i_enable  in  count this cycle
//   i_load    in  synchronous clear, used when a new frame starts
//   o_tick    out high on an enabled cycle where the count is at DIV-1
// ----------------------------------------------------------------------------
module bit8_bit_divider #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_enable,
    input  logic i_load,
    output logic o_tick
);

    // A 1-bit counter is kept for DIV=1 so the count is always 0 and every
    // enabled cycle becomes a terminal cycle.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    // Count enabled cycles only; wrap to zero after the terminal count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // The tick carries the enable so a stalled cycle never looks terminal.
    assign o_tick = i_enable & (r_count == LAST);

endmodule

// File: rtl/bit8_shift_transmitter.sv
// ----------------------------------------------------------------------------
// bit8_shift_transmitter
// Parallel-to-serial transmitter, LSB first, feeding a right-shifting
// receiver register (receiver enable = bit_strobe, serial in = sout).
// A word is taken over a valid/ready handshake and each bit is held on sout
// for DIV enabled clocks; bit_strobe marks the last cycle of each bit period.
// Build option: define PARITY_EN to append an even-parity bit period.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   e           in   global enable; 0 freezes the frame and suppresses strobes
//   tx_data     in   word to send, sampled on the handshake
//   tx_valid    in   producer has a word
//   tx_ready    out  block can accept a word (IDLE only)
//   sout        out  serial data line
//   bit_strobe  out  one-cycle pulse: sout is valid for sampling now
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse in the cycle after the last bit
// ----------------------------------------------------------------------------
module bit8_shift_transmitter
    import bit8_pkg::*;
#(
    parameter int WIDTH = BIT8_W,
    parameter int DIV   = BIT8_DIV_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             e,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sout,
    output logic             bit_strobe,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    tx_state_t       r_state;
    tx_state_t       w_nextState;
    logic [WIDTH-1:0] r_shreg;
    logic [CNTW-1:0] r_bitCnt;
    logic            w_handshake;
    logic            w_inBitPeriod;
    logic            w_counting;
    logic            w_tick;
    logic            w_lastBit;
`ifdef PARITY_EN
    logic            r_parity;
`endif

    // tx_ready is 1 throughout IDLE, so the handshake only needs the state,
    // the producer's valid and the global enable.
    assign w_handshake = (r_state == IDLE) & tx_valid & e;

`ifdef PARITY_EN
    assign w_inBitPeriod = (r_state == SHIFT) | (r_state == PARITY);
`else
    assign w_inBitPeriod = (r_state == SHIFT);
`endif

    assign w_counting = e & w_inBitPeriod;
    assign w_lastBit  = (r_bitCnt == LAST_BIT);

    bit8_bit_divider #(
        .DIV (DIV)
    ) u_divider (
        .clock    (clock),
        .reset    (reset),
        .i_enable (w_counting),
        .i_load   (w_handshake),
        .o_tick   (w_tick)
    );

    // State register; a reset mid-frame drops the frame for good.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. The tick already includes e, so a frozen cycle
    // never advances the FSM. DONE always lasts exactly one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick && w_lastBit) begin
`ifdef PARITY_EN
                    w_nextState = PARITY;
`else
                    w_nextState = DONE;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_nextState = DONE;
                end
            end
`endif
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: capture the word (and its parity) on the handshake, then
    // shift right once per bit period so shreg[0] is always the live bit.
    // Later tx_data changes cannot reach the frame in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shreg  <= '0;
            r_bitCnt <= '0;
`ifdef PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (w_handshake) begin
            r_shreg  <= tx_data;
            r_bitCnt <= '0;
`ifdef PARITY_EN
            r_parity <= ^tx_data;
`endif
        end else if ((r_state == SHIFT) && w_tick) begin
            r_shreg  <= {1'b0, r_shreg[WIDTH-1:1]};
            r_bitCnt <= r_bitCnt + CNTW'(1);
        end
    end

    // Outputs are decoded from registered state. sout follows the held
    // register contents, so it holds its value while e is low; the strobe
    // carries e through the divider tick, so a stalled cycle never strobes.
    always_comb begin
        tx_ready   = 1'b0;
        sout       = 1'b0;
        bit_strobe = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                tx_ready = 1'b1;
            end
            SHIFT: begin
                busy       = 1'b1;
                sout       = r_shreg[0];
                bit_strobe = w_tick;
            end
`ifdef PARITY_EN
            PARITY: begin
                busy       = 1'b1;
                sout       = r_parity;
                bit_strobe = w_tick;
            end
`endif
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: begin
                tx_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bit8_shift_transmitter.sv
// ----------------------------------------------------------------------------
// tb_bit8_shift_transmitter
// Self-checking bench for bit8_shift_transmitter. Two instances share clock
// and reset: dut4 (DIV=4) for single frames, stalls and mid-frame reset, and
// dut1 (DIV=1) for back-to-back frames. Each instance feeds a behavioural
// right-shift receiver; words expected at the far end are queued when the
// stimulus is driven and popped when the frame completes.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_bit8_shift_transmitter;

`ifdef PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam int DIV4 = 4;

    logic       clock;
    logic       reset;

    logic       e4;
    logic [7:0] txData4;
    logic       txValid4;
    logic       txReady4;
    logic       sout4;
    logic       bitStrobe4;
    logic       busy4;
    logic       frameDone4;

    logic       e1;
    logic [7:0] txData1;
    logic       txValid1;
    logic       txReady1;
    logic       sout1;
    logic       bitStrobe1;
    logic       busy1;
    logic       frameDone1;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] expQ4[$];
    logic [7:0] expQ1[$];

    bit8_shift_transmitter #(.WIDTH(8), .DIV(DIV4)) dut4 (
        .clock      (clock),
        .reset      (reset),
        .e          (e4),
        .tx_data    (txData4),
        .tx_valid   (txValid4),
        .tx_ready   (txReady4),
        .sout       (sout4),
        .bit_strobe (bitStrobe4),
        .busy       (busy4),
        .frame_done (frameDone4)
    );

    bit8_shift_transmitter #(.WIDTH(8), .DIV(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .e          (e1),
        .tx_data    (txData1),
        .tx_valid   (txValid1),
        .tx_ready   (txReady1),
        .sout       (sout1),
        .bit_strobe (bitStrobe1),
        .busy       (busy1),
        .frame_done (frameDone1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Receiver model for dut4: shifts sout in from the top on every strobe
    // and compares against the queued word when the frame completes.
    initial begin
        int         n4;
        logic [7:0] rx4;
        logic [7:0] want;
        n4  = 0;
        rx4 = 8'h00;
        forever begin
            @(negedge clock);
            if (reset) begin
                n4 = 0;
            end else begin
                if (bitStrobe4) begin
                    if (n4 < 8) rx4 = {sout4, rx4[7:1]};
                    n4++;
                end
                if (frameDone4) begin
                    checkOutput("rx4Strobes", 32'(n4), 32'(NBITS));
                    if (expQ4.size() == 0) begin
                        checks++;
                        errors++;
                        $error("[TB] FAIL rx4Unexpected: observed frame %0h expected none", rx4);
                    end else begin
                        want = expQ4.pop_front();
                        checkOutput("rx4Word", 32'(rx4), 32'(want));
                    end
                    n4 = 0;
                end
            end
        end
    end

    // Receiver model for dut1, same scheme.
    initial begin
        int         n1;
        logic [7:0] rx1;
        logic [7:0] want;
        n1  = 0;
        rx1 = 8'h00;
        forever begin
            @(negedge clock);
            if (reset) begin
                n1 = 0;
            end else begin
                if (bitStrobe1) begin
                    if (n1 < 8) rx1 = {sout1, rx1[7:1]};
                    n1++;
                end
                if (frameDone1) begin
                    checkOutput("rx1Strobes", 32'(n1), 32'(NBITS));
                    if (expQ1.size() == 0) begin
                        checks++;
                        errors++;
                        $error("[TB] FAIL rx1Unexpected: observed frame %0h expected none", rx1);
                    end else begin
                        want = expQ1.pop_front();
                        checkOutput("rx1Word", 32'(rx1), 32'(want));
                    end
                    n1 = 0;
                end
            end
        end
    end

    // Sends one word on dut4, starting 1 unit after a rising edge. e is
    // low for cycles [stallAt, stallAt+stallLen). If abortAt is nonzero,
    // reset is asserted in the cycle after that many strobes.
    task automatic applyStimulus(input logic [7:0] word, input int stallAt,
                                 input int stallLen, input int abortAt);
        int   strobes;
        int   doneCycle;
        int   expCyc;
        logic holdSout;
        logic expBit;
        bit   aborted;
        strobes   = 0;
        doneCycle = -1;
        holdSout  = 1'b0;
        aborted   = 1'b0;
        txData4   = word;
        txValid4  = 1'b1;
        e4        = 1'b1;
        if (abortAt == 0) expQ4.push_back(word);
        @(negedge clock);
        checkOutput("handshakeReady", 32'(txReady4), 32'd1);
        for (int c = 1; c < 300 && doneCycle < 0 && !aborted; c++) begin
            @(posedge clock);
            #1;
            txValid4 = 1'b0;
            txData4  = ~word;
            e4       = !(c >= stallAt && c < stallAt + stallLen);
            if (abortAt != 0 && strobes == abortAt) begin
                reset = 1'b1;
                @(negedge clock);
                checkOutput("abortReady", 32'(txReady4), 32'd1);
                checkOutput("abortSout", 32'(sout4), 32'd0);
                checkOutput("abortBusy", 32'(busy4), 32'd0);
                checkOutput("abortStrobe", 32'(bitStrobe4), 32'd0);
                checkOutput("abortDone", 32'(frameDone4), 32'd0);
                @(posedge clock);
                #1;
                reset   = 1'b0;
                aborted = 1'b1;
            end else begin
                @(negedge clock);
                if (c == 1) begin
                    checkOutput("readyDrops", 32'(txReady4), 32'd0);
                    checkOutput("busyRises", 32'(busy4), 32'd1);
                end
                if (!e4) begin
                    checkOutput("stallNoStrobe", 32'(bitStrobe4), 32'd0);
                    checkOutput("stallSoutHold", 32'(sout4), 32'(holdSout));
                end else begin
                    holdSout = sout4;
                end
                if (bitStrobe4) begin
                    expCyc = (strobes + 1) * DIV4;
                    if (stallLen > 0 && expCyc >= stallAt) expCyc += stallLen;
                    checkOutput("strobeCycle", 32'(c), 32'(expCyc));
                    expBit = (strobes < 8) ? word[strobes] : ^word;
                    checkOutput("strobeBit", 32'(sout4), 32'(expBit));
                    strobes++;
                end
                if (frameDone4) begin
                    doneCycle = c;
                    checkOutput("doneNoStrobe", 32'(bitStrobe4), 32'd0);
                    checkOutput("doneReady", 32'(txReady4), 32'd0);
                end
            end
        end
        if (!aborted) begin
            checkOutput("strobeCount", 32'(strobes), 32'(NBITS));
            checkOutput("doneCycle", 32'(doneCycle), 32'(NBITS * DIV4 + 1 + stallLen));
            @(posedge clock);
            #1;
            @(negedge clock);
            checkOutput("idleReady", 32'(txReady4), 32'd1);
            checkOutput("idleBusy", 32'(busy4), 32'd0);
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int         h2;
        int         k;
        logic [7:0] w;
        logic       expBit;
        logic       expStrobe;

        reset    = 1'b1;
        e4       = 1'b1;
        txData4  = 8'h00;
        txValid4 = 1'b0;
        e1       = 1'b1;
        txData1  = 8'h00;
        txValid1 = 1'b0;

        // Reset held for three cycles: idle outputs, no strobes.
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("rstReady", 32'(txReady4), 32'd1);
        checkOutput("rstSout", 32'(sout4), 32'd0);
        checkOutput("rstBusy", 32'(busy4), 32'd0);
        checkOutput("rstStrobe", 32'(bitStrobe4), 32'd0);
        checkOutput("rstDone", 32'(frameDone4), 32'd0);
        checkOutput("rstReady1", 32'(txReady1), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("postRstStrobe", 32'(bitStrobe4), 32'd0);
        checkOutput("postRstReady", 32'(txReady4), 32'd1);
        @(posedge clock);
        #1;

        // e low in IDLE: tx_valid is ignored.
        e4       = 1'b0;
        txValid4 = 1'b1;
        txData4  = 8'h55;
        repeat (3) begin
            @(negedge clock);
            checkOutput("eLowIdleReady", 32'(txReady4), 32'd1);
            checkOutput("eLowIdleBusy", 32'(busy4), 32'd0);
            @(posedge clock);
            #1;
        end
        txValid4 = 1'b0;
        e4       = 1'b1;

        $display("[TB] basic frame 8'hA5");
        applyStimulus(8'hA5, 0, 0, 0);
        $display("[TB] stalled frame 8'h3C");
        applyStimulus(8'h3C, 14, 5, 0);
        $display("[TB] mid-frame reset on 8'hFF, then 8'h01");
        applyStimulus(8'hFF, 0, 0, 2);
        applyStimulus(8'h01, 0, 0, 0);
`ifdef PARITY_EN
        $display("[TB] parity frames 8'h07 and 8'h03");
        applyStimulus(8'h07, 0, 0, 0);
        applyStimulus(8'h03, 0, 0, 0);
`endif

        // Back-to-back on dut1 with tx_valid held across both words.
        $display("[TB] back-to-back DIV=1");
        h2 = NBITS + 2;
        expQ1.push_back(8'h81);
        expQ1.push_back(8'h7E);
        txData1  = 8'h81;
        txValid1 = 1'b1;
        for (int c = 0; c <= h2 + NBITS + 3; c++) begin
            @(negedge clock);
            expStrobe = (c >= 1 && c <= NBITS) || (c >= h2 + 1 && c <= h2 + NBITS);
            checkOutput("b2bStrobe", 32'(bitStrobe1), 32'(expStrobe));
            checkOutput("b2bDone", 32'(frameDone1),
                        32'((c == NBITS + 1) || (c == h2 + NBITS + 1)));
            checkOutput("b2bReady", 32'(txReady1),
                        32'((c == 0) || (c == h2) || (c >= h2 + NBITS + 2)));
            if (bitStrobe1) begin
                w      = (c > h2) ? 8'h7E : 8'h81;
                k      = (c > h2) ? (c - 1 - h2) : (c - 1);
                expBit = (k < 8) ? w[k] : ^w;
                checkOutput("b2bBit", 32'(sout1), 32'(expBit));
            end
            @(posedge clock);
            #1;
            if (c == 0) txData1 = 8'h7E;
            if (c == h2) begin
                txValid1 = 1'b0;
                txData1  = 8'h00;
            end
        end

        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("q4Drained", 32'(expQ4.size()), 32'd0);
        checkOutput("q1Drained", 32'(expQ1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
